core_load_sequencer: RTL and testbench
======================================

// Module: core_load_sequencer
// PURPOSE
//   Hardware responder for the core's req/ack load protocol; replaces bench-driven sequencing. On start,
//   walks all kernel positions: answers weight (req[0]) and activation (req[1]) requests by streaming
//   SRAM reads onto in_corelet, then issues SFU accumulate and waits. Sits between sram_32b_w2048 and core.
// PARAMETERS
//   CHANNELS        8     output channels; weight rows streamed per kernel position
//   LEN_NI          6     padded activation row length (SRAM row stride)
//   LEN_NI_UNPAD    4     unpadded output row length; activation stream = LEN_NI_UNPAD^2 reads
//   LEN_KI          3     kernel width; kernel positions = LEN_KI^2
//   ADDR_W          11    SRAM address width
//   W_BASE          1024  weight region base address
//   X_BASE          0     activation region base address
//   DRAIN_CYCLES    8     cycles ack[1] is held after last activation read
//   GAP_CYCLES      20    idle cycles between kernel positions
//   ACC_CYCLES      200   wait cycles after SFU accumulate pulse
// PORTS
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-low reset
//   start      in   1       1-cycle pulse: begin a full layer pass
//   req        in   4       core request lines; [0] weight, [1] activation used
//   ack        out  4       acknowledge to core; [3:2] tied 0
//   inst_load  out  1       weight-load instruction to core (inst_corelet[4])
//   mem_cen    out  1       SRAM chip enable, active-low
//   mem_wen    out  1       SRAM write enable, active-low; constant 1 (read-only)
//   mem_a      out  ADDR_W  SRAM address
//   sfu_acc    out  1       SFU accumulate instruction (sfu inst[1]), 1-cycle pulse
//   kij        out  4       current kernel position ky*LEN_KI+kx
//   busy       out  1       high from start accepted until done
//   done       out  1       1-cycle pulse at end of pass
// BEHAVIOUR
//   All outputs registered. Reset (reset=0, async): state IDLE, ack=0, inst_load=0, mem_cen=1,
//   mem_wen=1, mem_a=0, sfu_acc=0, kij=0, busy=0, done=0; any in-flight pass is abandoned.
//   States: IDLE, W_REQ, W_STREAM, X_WAIT, X_STREAM, X_DRAIN, GAP, ACC, ACC_WAIT, DONE.
//   IDLE: start=1 -> W_REQ, busy=1, kij=0. start while busy ignored.
//   W_REQ: inst_load=1; on req[0]=1 -> W_STREAM next cycle (req already high: 1 cycle in W_REQ).
//   W_STREAM: inst_load=0, ack[0]=1, mem_cen=0, CHANNELS cycles, mem_a = W_BASE+kij*CHANNELS+oc with
//     oc CHANNELS-1 down to 0 (one address/cycle). Exit -> X_WAIT with ack[0]=0, mem_cen=1.
//   X_WAIT: wait req[1]=1 -> X_STREAM.
//   X_STREAM: ack[1]=1, mem_cen=0, LEN_NI_UNPAD^2 cycles, mem_a = X_BASE+(ny+ky)*LEN_NI+(nx+kx),
//     nx inner, ny outer, ky=kij/LEN_KI, kx=kij%LEN_KI. Exit -> X_DRAIN.
//   X_DRAIN: ack[1]=1, mem_cen=1, DRAIN_CYCLES cycles -> GAP with ack[1]=0.
//   GAP: GAP_CYCLES cycles; then kij==LEN_KI^2-1 -> ACC, else kij+1 -> W_REQ.
//   ACC: sfu_acc=1 exactly one cycle -> ACC_WAIT; ACC_WAIT: ACC_CYCLES cycles -> DONE.
//   DONE: done=1 one cycle, busy=0, kij=0 -> IDLE. start in DONE cycle ignored.
//   ack[0] and ack[1] never high together; ack high only in stream/drain states.
//   req deasserting mid-stream ignored: stream always completes its full count.
//   Address arithmetic in ADDR_W bits, no saturation; parameters must keep addresses in range.
//   Read data valid on in_corelet one cycle after each mem_cen=0 address (SRAM latency 1).
// TESTING
//   1 Reset mid X_STREAM (kij=4) -> all outputs at reset values same cycle; start afterwards runs kij=0.
//   2 start, req[0] tied 1 -> W_REQ 1 cycle; 8 reads at 1031..1024 with ack[0]=1; no extra reads.
//   3 kij=5 (ky=1,kx=2) -> activation addresses 8,9,10,11,14..17,20..23,26..29; ack[1] 16+8 cycles.
//   4 Core model delays req[1] 10 cycles -> mem_cen=1, ack=0 throughout wait; stream unchanged after.
//   5 Full pass with core + SRAM + psum.txt check -> 9 weight/activation loads, one sfu_acc pulse,
//     done pulse once, all 16x8 psums match; start pulsed mid-pass has no effect.
//   6 Assert: ack[0]&ack[1]==0 and mem_wen==1 every cycle; sfu_acc width exactly 1 cycle.

Source files
------------

// File: rtl/core_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : core_load_sequencer_if
// Description : Handshake and SRAM bus between the load sequencer, the core
//               (req/ack, inst_load, sfu_acc) and the weight/activation SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_load_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic [3:0]        req;
  logic [3:0]        ack;
  logic              inst_load;
  logic              mem_cen;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_a;
  logic              sfu_acc;

  // Sequencer side: answers requests and drives the SRAM/SFU controls.
  modport master (
    input  req,
    output ack, inst_load, mem_cen, mem_wen, mem_a, sfu_acc
  );

  // Core/SRAM side: raises requests and consumes the controls.
  modport slave (
    output req,
    input  ack, inst_load, mem_cen, mem_wen, mem_a, sfu_acc
  );
endinterface
`default_nettype wire

// File: rtl/core_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_load_sequencer
// Description : Walks every kernel position of a layer pass. For each one it
//               streams CHANNELS weight rows and LEN_NI_UNPAD^2 activation
//               rows from SRAM in answer to the core's req lines, then idles
//               and finally issues one SFU accumulate and waits for it.
// Revision    : 1.0 - initial release
// ============================================================================
module core_load_sequencer #(
  parameter int CHANNELS     = 8,
  parameter int LEN_NI       = 6,
  parameter int LEN_NI_UNPAD = 4,
  parameter int LEN_KI       = 3,
  parameter int ADDR_W       = 11,
  parameter int W_BASE       = 1024,
  parameter int X_BASE       = 0,
  parameter int DRAIN_CYCLES = 8,
  parameter int GAP_CYCLES   = 20,
  parameter int ACC_CYCLES   = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  core_load_sequencer_if.master bus,
  output logic [3:0]            kij,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam cnt_t       C_ONE    = cnt_t'(1);
  localparam cnt_t       C_W_LAST = cnt_t'(CHANNELS - 1);
  localparam cnt_t       C_D_LAST = cnt_t'(DRAIN_CYCLES - 1);
  localparam cnt_t       C_G_LAST = cnt_t'(GAP_CYCLES - 1);
  localparam cnt_t       C_A_LAST = cnt_t'(ACC_CYCLES - 1);
  localparam addr_t      C_A_ONE  = addr_t'(1);
  localparam logic [7:0] C_N_LAST = 8'(LEN_NI_UNPAD - 1);
  localparam logic [3:0] C_K_LAST = 4'(LEN_KI - 1);
  localparam logic [3:0] C_KIJ_LAST = 4'(LEN_KI * LEN_KI - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    W_REQ    = 4'd1,
    W_STREAM = 4'd2,
    X_WAIT   = 4'd3,
    X_STREAM = 4'd4,
    X_DRAIN  = 4'd5,
    GAP      = 4'd6,
    ACC      = 4'd7,
    ACC_WAIT = 4'd8,
    DONE     = 4'd9
  } state_t;

  state_t     state;
  cnt_t       cnt;
  logic [7:0] nx;
  logic [7:0] ny;
  logic [3:0] kx;
  logic [3:0] ky;
  logic       ack_w;
  logic       ack_x;
  logic       inst_load_r;
  logic       mem_cen_r;
  addr_t      mem_a_r;
  logic       sfu_acc_r;

  // Only the weight and activation request lines are meaningful.
  logic unused_req;
  assign unused_req = ^bus.req[3:2];

  // Weight rows for a kernel position are read highest output channel first.
  function automatic addr_t w_first(input logic [3:0] k);
    return addr_t'(W_BASE + int'(k) * CHANNELS + CHANNELS - 1);
  endfunction

  // Activation address of output pixel (y, x) shifted by kernel offset (ry, rx).
  function automatic addr_t x_addr(input logic [7:0] y, input logic [7:0] x,
                                   input logic [3:0] ry, input logic [3:0] rx);
    return addr_t'(X_BASE + (int'(y) + int'(ry)) * LEN_NI + int'(x) + int'(rx));
  endfunction

  assign bus.ack       = {2'b00, ack_x, ack_w};
  assign bus.inst_load = inst_load_r;
  assign bus.mem_cen   = mem_cen_r;
  assign bus.mem_wen   = 1'b1;
  assign bus.mem_a     = mem_a_r;
  assign bus.sfu_acc   = sfu_acc_r;

  // Pass sequencer: state, counters and every registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      nx          <= '0;
      ny          <= '0;
      kx          <= '0;
      ky          <= '0;
      ack_w       <= 1'b0;
      ack_x       <= 1'b0;
      inst_load_r <= 1'b0;
      mem_cen_r   <= 1'b1;
      mem_a_r     <= '0;
      sfu_acc_r   <= 1'b0;
      kij         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= W_REQ;
            busy        <= 1'b1;
            kij         <= '0;
            kx          <= '0;
            ky          <= '0;
            inst_load_r <= 1'b1;
          end
        end
        W_REQ: begin
          if (bus.req[0]) begin
            state       <= W_STREAM;
            inst_load_r <= 1'b0;
            ack_w       <= 1'b1;
            mem_cen_r   <= 1'b0;
            mem_a_r     <= w_first(kij);
            cnt         <= '0;
          end
        end
        W_STREAM: begin
          // The stream always runs to its full count, whatever req does.
          if (cnt == C_W_LAST) begin
            state     <= X_WAIT;
            ack_w     <= 1'b0;
            mem_cen_r <= 1'b1;
          end else begin
            cnt     <= cnt + C_ONE;
            mem_a_r <= mem_a_r - C_A_ONE;
          end
        end
        X_WAIT: begin
          if (bus.req[1]) begin
            state     <= X_STREAM;
            ack_x     <= 1'b1;
            mem_cen_r <= 1'b0;
            nx        <= '0;
            ny        <= '0;
            mem_a_r   <= x_addr(8'd0, 8'd0, ky, kx);
          end
        end
        X_STREAM: begin
          if (nx == C_N_LAST && ny == C_N_LAST) begin
            state     <= X_DRAIN;
            mem_cen_r <= 1'b1;
            cnt       <= '0;
          end else if (nx == C_N_LAST) begin
            nx      <= '0;
            ny      <= ny + 8'd1;
            mem_a_r <= x_addr(ny + 8'd1, 8'd0, ky, kx);
          end else begin
            nx      <= nx + 8'd1;
            mem_a_r <= x_addr(ny, nx + 8'd1, ky, kx);
          end
        end
        X_DRAIN: begin
          // ack[1] stays up while the last reads travel through the core.
          if (cnt == C_D_LAST) begin
            state <= GAP;
            ack_x <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        GAP: begin
          if (cnt == C_G_LAST) begin
            cnt <= '0;
            if (kij == C_KIJ_LAST) begin
              state     <= ACC;
              sfu_acc_r <= 1'b1;
            end else begin
              state       <= W_REQ;
              inst_load_r <= 1'b1;
              kij         <= kij + 4'd1;
              if (kx == C_K_LAST) begin
                kx <= '0;
                ky <= ky + 4'd1;
              end else begin
                kx <= kx + 4'd1;
              end
            end
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        ACC: begin
          state     <= ACC_WAIT;
          sfu_acc_r <= 1'b0;
          cnt       <= '0;
        end
        ACC_WAIT: begin
          if (cnt == C_A_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            kij   <= '0;
            kx    <= '0;
            ky    <= '0;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_load_sequencer
// Description : Scoreboard bench for core_load_sequencer: expected SRAM reads
//               are queued per pass and popped by a monitor on every read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_load_sequencer;

  localparam int CH = 8;
  localparam int NI = 6;
  localparam int NU = 4;
  localparam int KI = 3;
  localparam int AW = 11;
  localparam int WB = 1024;
  localparam int XB = 0;
  localparam int DR = 8;
  localparam int GP = 20;
  localparam int AC = 200;
  // Cycles with busy=1 for one undelayed pass: 9 * (1+8+1+16+8+20) + 1 + 200.
  localparam int PASS_BUSY = 687;
  localparam int X_DELAY   = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    ack;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] kij;
  logic       busy;
  logic       done;

  core_load_sequencer_if #(.ADDR_W(AW)) bus ();

  core_load_sequencer #(
    .CHANNELS(CH), .LEN_NI(NI), .LEN_NI_UNPAD(NU), .LEN_KI(KI), .ADDR_W(AW),
    .W_BASE(WB), .X_BASE(XB), .DRAIN_CYCLES(DR), .GAP_CYCLES(GP), .ACC_CYCLES(AC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .kij(kij), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  exp_t          sbq[$];
  logic [AW-1:0] cap_w0[$];
  logic [AW-1:0] cap_x5[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt, done_cnt, sfu_cnt, inst_cnt, ack1_cnt, sfu_cyc, done_cyc;
  logic sfu_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_counters();
    busy_cnt = 0; done_cnt = 0; sfu_cnt = 0; inst_cnt = 0; ack1_cnt = 0;
    sfu_cyc = 0; done_cyc = 0;
    cap_w0.delete();
    cap_x5.delete();
  endtask

  // Expected read stream of one full pass.
  task automatic push_pass();
    exp_t e;
    for (int k = 0; k < KI * KI; k++) begin
      for (int oc = CH - 1; oc >= 0; oc--) begin
        e.addr = AW'(WB + k * CH + oc);
        e.ack  = 4'b0001;
        sbq.push_back(e);
      end
      for (int y = 0; y < NU; y++) begin
        for (int x = 0; x < NU; x++) begin
          e.addr = AW'(XB + (y + k / KI) * NI + x + k % KI);
          e.ack  = 4'b0010;
          sbq.push_back(e);
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_within_budget", seen, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, bus.ack, 0);
    check({tag, "_inst_load"}, bus.inst_load, 0);
    check({tag, "_mem_cen"}, bus.mem_cen, 1);
    check({tag, "_mem_wen"}, bus.mem_wen, 1);
    check({tag, "_mem_a"}, bus.mem_a, 0);
    check({tag, "_sfu_acc"}, bus.sfu_acc, 0);
    check({tag, "_kij"}, kij, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every SRAM read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc++;
        check("ack_exclusive", bus.ack[0] & bus.ack[1], 0);
        check("ack_upper_zero", bus.ack[3:2], 0);
        check("mem_wen_high", bus.mem_wen, 1);
        check("sfu_acc_width", {sfu_prev, bus.sfu_acc} == 2'b11, 0);
        sfu_prev = bus.sfu_acc;
        if (busy) busy_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (bus.sfu_acc) begin sfu_cnt++; sfu_cyc = cyc; end
        if (bus.inst_load) inst_cnt++;
        if (bus.ack[1]) ack1_cnt++;
        if (!bus.mem_cen) begin
          if (bus.ack[0] && kij == 4'd0) cap_w0.push_back(bus.mem_a);
          if (bus.ack[1] && kij == 4'd5) cap_x5.push_back(bus.mem_a);
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: got addr %0d expected no read (t=%0t)", bus.mem_a, $time);
          end else begin
            e = sbq.pop_front();
            if (bus.mem_a !== e.addr || bus.ack !== e.ack) begin
              errors++;
              $display("FAIL read: got addr %0d ack %b expected addr %0d ack %b (t=%0t)",
                       bus.mem_a, bus.ack, e.addr, e.ack, $time);
            end
          end
        end
      end else begin
        sfu_prev = 1'b0;
      end
    end
  end

  initial begin
    logic [AW-1:0] hand_w0 [8];
    logic [AW-1:0] hand_x5 [16];
    bit            hit;
    bit            seen_w;

    hand_w0 = '{11'd1031, 11'd1030, 11'd1029, 11'd1028, 11'd1027, 11'd1026, 11'd1025, 11'd1024};
    hand_x5 = '{11'd8, 11'd9, 11'd10, 11'd11, 11'd14, 11'd15, 11'd16, 11'd17,
                11'd20, 11'd21, 11'd22, 11'd23, 11'd26, 11'd27, 11'd28, 11'd29};

    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    @(negedge clk);

    // Pass A: requests tied high, stray start mid-pass and in the done cycle.
    bus.req = 4'b0011;
    clear_counters();
    push_pass();
    pulse_start();
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_done_ignored", busy, 0);
    check("passA_busy_cycles", busy_cnt, PASS_BUSY);
    check("passA_done_pulses", done_cnt, 1);
    check("passA_sfu_pulses", sfu_cnt, 1);
    check("passA_sfu_to_done", done_cyc - sfu_cyc, AC + 1);
    check("passA_inst_load_cycles", inst_cnt, KI * KI);
    check("passA_ack1_cycles", ack1_cnt, KI * KI * (NU * NU + DR));
    check("passA_reads_left", sbq.size(), 0);
    check("kij0_weight_count", cap_w0.size(), 8);
    for (int i = 0; i < 8 && i < cap_w0.size(); i++) check("kij0_weight_addr", cap_w0[i], hand_w0[i]);
    check("kij5_act_count", cap_x5.size(), 16);
    for (int i = 0; i < 16 && i < cap_x5.size(); i++) check("kij5_act_addr", cap_x5[i], hand_x5[i]);

    // Pass B: reset lands in the middle of the kij=4 activation stream.
    clear_counters();
    push_pass();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (kij == 4'd4 && bus.ack[1] && !bus.mem_cen) hit = 1'b1;
    end
    check("reach_kij4_stream", hit, 1);
    #2 reset = 1'b0;
    #1 check_reset_values("midpass");
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Pass C: activation request held back X_DELAY cycles on kij=0.
    bus.req = 4'b0001;
    clear_counters();
    push_pass();
    pulse_start();
    seen_w = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (bus.ack[0] && !seen_w) begin
        seen_w = 1'b1;
        check("restart_kij0", kij, 0);
      end
      if (seen_w && !bus.ack[0]) hit = 1'b1;
    end
    check("reach_x_wait", hit, 1);
    for (int i = 0; i < X_DELAY; i++) begin
      check("xwait_mem_cen", bus.mem_cen, 1);
      check("xwait_ack", bus.ack, 0);
      @(negedge clk);
    end
    check("xwait_mem_cen", bus.mem_cen, 1);
    check("xwait_ack", bus.ack, 0);
    bus.req = 4'b0011;
    wait_done(2000);
    @(negedge clk);
    check("passC_busy_cycles", busy_cnt, PASS_BUSY + X_DELAY);
    check("passC_done_pulses", done_cnt, 1);
    check("passC_sfu_pulses", sfu_cnt, 1);
    check("passC_reads_left", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
